// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream instruction/operand handshake plus the ALU command handshake.
// The slave modport is the issue stage itself; master is its environment.
interface alu_issue_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      ALU_control;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            out_illegal;

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, ALU_control, op1, op2, out_illegal
  );

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, ALU_control, op1, op2, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue slice: decodes into an ALU command and registers it behind a
// valid/ready handshake with a one-entry skid register for full throughput.
module alu_issue_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned LINK_OFFSET = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  alu_issue_stage_if.slave  bus
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcJal   = 7'b1101111;
  localparam logic [6:0] OpcJalr  = 7'b1100111;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluSll = 4'b0101;
  localparam logic [3:0] AluSrl = 4'b0111;

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            illegal;
  } cmd_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            dec_legal;
  cmd_t            dec;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign imm_i  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_u  = {bus.instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, bus.instr[24:20]};

  // Register-specifier field is resolved upstream; only its read data arrives here.
  logic unused_rs1_field;
  assign unused_rs1_field = ^bus.instr[19:15];

  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    unique case (opcode)
      OpcOp: begin
        dec.op1   = bus.rs1_data;
        dec.op2   = bus.rs2_data;
        dec_legal = (funct7 == 7'b0000000) || (funct3 == 3'b000 && funct7 == 7'b0100000);
        case (funct3)
          3'b000:  dec.ctrl = funct7[5] ? AluSub : AluAdd;
          3'b001:  dec.ctrl = AluSll;
          3'b101:  dec.ctrl = AluSrl;
          3'b111:  dec.ctrl = AluAnd;
          3'b110:  dec.ctrl = AluOr;
          3'b100:  dec.ctrl = AluXor;
          default: dec_legal = 1'b0;
        endcase
      end
      OpcOpImm: begin
        dec.op1 = bus.rs1_data;
        dec.op2 = imm_i;
        case (funct3)
          3'b000:  dec.ctrl = AluAdd;
          3'b111:  dec.ctrl = AluAnd;
          3'b110:  dec.ctrl = AluOr;
          3'b100:  dec.ctrl = AluXor;
          3'b001: begin
            dec.ctrl  = AluSll;
            dec.op2   = shamt;
            dec_legal = (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec.ctrl  = AluSrl;
            dec.op2   = shamt;
            dec_legal = (funct7 == 7'b0000000);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OpcLoad: begin
        dec.op1 = bus.rs1_data;
        dec.op2 = imm_i;
      end
      OpcStore: begin
        dec.op1 = bus.rs1_data;
        dec.op2 = imm_s;
      end
      OpcLui:   dec.op2 = imm_u;
      OpcAuipc: begin
        dec.op1 = bus.pc;
        dec.op2 = imm_u;
      end
      OpcJal, OpcJalr: begin
        dec.op1 = bus.pc;
        dec.op2 = XLEN'(LINK_OFFSET);
      end
      default: dec_legal = 1'b0;
    endcase
    // Illegal commands carry no operands so the ALU sees a harmless ADD 0,0.
    if (!dec_legal) begin
      dec = '0;
    end
    dec.illegal = !dec_legal;
  end

  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  cmd_t out_cmd_q, out_cmd_d;
  cmd_t skid_cmd_q, skid_cmd_d;
  logic accept;

  assign accept = bus.in_valid && !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_cmd_d    = out_cmd_q;
    skid_valid_d = skid_valid_q;
    skid_cmd_d   = skid_cmd_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      // Skid entry is older than anything upstream; it always drains first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_cmd_d    = skid_cmd_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_cmd_d   = dec;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_cmd_d   = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_cmd_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_cmd_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_cmd_q    <= out_cmd_d;
      skid_valid_q <= skid_valid_d;
      skid_cmd_q   <= skid_cmd_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.ALU_control = out_cmd_q.ctrl;
  assign bus.op1         = out_cmd_q.op1;
  assign bus.op2         = out_cmd_q.op2;
  assign bus.out_illegal = out_cmd_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue-based reference of the two-entry stage plus
// directed instruction vectors with hand-computed expectations.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        ill;
  } cmd_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   total;
  int   bad;
  bit   started;
  bit   rec;
  cmd_t held[$];
  logic [31:0] delivered[$];

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32), .LINK_OFFSET(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // ALU code for a funct3 among the ALU-executable ops, -1 otherwise.
  function automatic int f3_code(input int f3);
    case (f3)
      0: return 0;
      1: return 5;
      4: return 4;
      5: return 7;
      6: return 3;
      7: return 2;
      default: return -1;
    endcase
  endfunction

  function automatic cmd_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                 input logic [31:0] r1, input logic [31:0] r2);
    int f3;
    int f7;
    int code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    cmd_t c;
    f3    = int'(ins[14:12]);
    f7    = int'(ins[31:25]);
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_u = {ins[31:12], 12'h000};
    code  = 0;
    a     = r1;
    b     = 0;
    case (ins[6:0])
      7'h33: begin
        b = r2;
        if (f7 == 0) code = f3_code(f3);
        else if (f7 == 32 && f3 == 0) code = 1;
        else code = -1;
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          b    = 32'(ins[24:20]);
          code = (f7 == 0) ? f3_code(f3) : -1;
        end else begin
          b    = imm_i;
          code = f3_code(f3);
        end
      end
      7'h03: b = imm_i;
      7'h23: b = imm_s;
      7'h37: begin a = 0;   b = imm_u; end
      7'h17: begin a = pcv; b = imm_u; end
      7'h6F, 7'h67: begin a = pcv; b = 4; end
      default: code = -1;
    endcase
    if (code < 0) c = '{ctrl: 4'h0, op1: 32'h0, op2: 32'h0, ill: 1'b1};
    else c = '{ctrl: code[3:0], op1: a, op2: b, ill: 1'b0};
    return c;
  endfunction

  // Reference: the stage holds an ordered list of at most two commands.
  always @(posedge clk) begin
    bit acc;
    if (!rst_n) started = 1'b1;
    if (!rst_n || flush) begin
      held.delete();
    end else begin
      acc = bus.in_valid && (held.size() < 2);
      if (held.size() > 0 && bus.out_ready) void'(held.pop_front());
      if (acc) held.push_back(model(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data));
    end
    if (rec && rst_n && !flush && bus.out_valid && bus.out_ready) delivered.push_back(bus.op2);
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, held.size() < 2});
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, held.size() > 0});
      if (held.size() > 0) begin
        chk("ALU_control", {28'b0, bus.ALU_control}, {28'b0, held[0].ctrl});
        chk("op1", bus.op1, held[0].op1);
        chk("op2", bus.op2, held[0].op2);
        chk("out_illegal", {31'b0, bus.out_illegal}, {31'b0, held[0].ill});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid = v;
    bus.instr    = ins;
    bus.pc       = pcv;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
  endtask

  task automatic issue1(input logic [31:0] ins, input logic [31:0] pcv,
                        input logic [31:0] r1, input logic [31:0] r2);
    drive(1'b1, ins, pcv, r1, r2);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                            input logic [31:0] b, input logic ill);
    chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({tag, "_ctrl"}, {28'b0, bus.ALU_control}, {28'b0, ctrl});
    chk({tag, "_op1"}, bus.op1, a);
    chk({tag, "_op2"}, bus.op2, b);
    chk({tag, "_illegal"}, {31'b0, bus.out_illegal}, {31'b0, ill});
  endtask

  task automatic expect_clear(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    chk({tag, "_ctrl"}, {28'b0, bus.ALU_control}, 32'd0);
    chk({tag, "_op1"}, bus.op1, 32'd0);
    chk({tag, "_op2"}, bus.op2, 32'd0);
    chk({tag, "_illegal"}, {31'b0, bus.out_illegal}, 32'd0);
  endtask

  logic [31:0] extra[10] = '{
    32'h40208233,  // sub x4,x1,x2
    32'h0020E2B3,  // or x5,x1,x2
    32'h0020F2B3,  // and x5,x1,x2
    32'h0020C2B3,  // xor x5,x1,x2
    32'h01F11093,  // slli x1,x2,31
    32'h40315093,  // srai: illegal
    32'h00208463,  // beq: illegal
    32'h022081B3,  // mul (funct7 1): illegal
    32'h00001117,  // auipc x2,1
    32'h0040A103   // lw x2,4(x1)
  };

  initial begin
    int idx;
    int cyc;
    bit acc;
    logic [31:0] items[4];
    total = 0;
    bad   = 0;
    rec   = 1'b0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    expect_clear("reset");
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    issue1(32'h002081B3, 32'h0, 32'd5, 32'd7);
    expect_out("add", 4'b0000, 32'd5, 32'd7, 1'b0);
    issue1(32'h00315093, 32'h0, 32'h000000F0, 32'h0);
    expect_out("srli", 4'b0111, 32'h000000F0, 32'd3, 1'b0);
    issue1(32'hFFF00093, 32'h0, 32'h00000055, 32'h0);
    expect_out("addi_neg", 4'b0000, 32'h00000055, 32'hFFFFFFFF, 1'b0);
    issue1(32'h123452B7, 32'h0, 32'h0000DEAD, 32'h0);
    expect_out("lui", 4'b0000, 32'h0, 32'h12345000, 1'b0);
    issue1(32'h0000006F, 32'h00000100, 32'd1, 32'd2);
    expect_out("jal", 4'b0000, 32'h00000100, 32'd4, 1'b0);
    issue1(32'hFE20AE23, 32'h0, 32'h00001000, 32'd9);
    expect_out("sw_neg", 4'b0000, 32'h00001000, 32'hFFFFFFFC, 1'b0);
    issue1(32'h403150B3, 32'h0, 32'd3, 32'd4);
    expect_out("sra", 4'b0000, 32'h0, 32'h0, 1'b1);
    issue1(32'h0020A1B3, 32'h0, 32'd3, 32'd4);
    expect_out("slt", 4'b0000, 32'h0, 32'h0, 1'b1);
    foreach (extra[i]) issue1(extra[i], 32'h00000200, 32'h0F0F1234, 32'h00000013);
    tick();

    // Back-to-back stream against three stalled cycles.
    for (int k = 0; k < 4; k++) items[k] = (32'(k + 1) << 20) | 32'h00000093;
    rec = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      bus.out_ready = (cyc >= 3);
      drive(1'b1, items[idx], 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      acc = bus.in_ready;
      if (cyc == 2) chk("stream_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
      if (cyc == 1 || cyc == 2) chk("stall_hold_op2", bus.op2, 32'd1);
      tick();
      if (acc) idx++;
      cyc++;
    end
    chk("stream_all_accepted", idx, 32'd4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    rec = 1'b0;
    chk("stream_count", delivered.size(), 32'd4);
    foreach (delivered[i]) chk("stream_order", delivered[i], 32'(i + 1));

    // Flush with both entries full, then with an accept in flight.
    bus.out_ready = 1'b0;
    issue1(32'h00A00093, 32'h0, 32'h0, 32'h0);
    issue1(32'h00B00093, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 32'h00C00093, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_full_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_full_ready", {31'b0, bus.in_ready}, 32'd1);
    issue1(32'h00D00093, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 32'h00E00093, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_accept_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_accept_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_ghost", {31'b0, bus.out_valid}, 32'd0);

    // Reset in the middle of a stall.
    bus.out_ready = 1'b0;
    issue1(32'h00F00093, 32'h0, 32'h11, 32'h0);
    issue1(32'h01000093, 32'h0, 32'h22, 32'h0);
    drive(1'b1, 32'h01100093, 32'h0, 32'h33, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    expect_clear("midreset");
    bus.out_ready = 1'b1;
    tick();
    chk("midreset_idle", {31'b0, bus.out_valid}, 32'd0);

    issue1(32'h002081B3, 32'h0, 32'd100, 32'd23);
    expect_out("post_reset_add", 4'b0000, 32'd100, 32'd23, 1'b0);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
